branch_predict_flush_unit: RTL and testbench

Branch resolution and prediction unit for the 5-stage RV32 pipeline. It predicts direction and target in IF from a direct-mapped BTB with 2-bit saturating counters. It resolves all six RV32I conditional branches plus JAL/JALR in EX, and raises a flush and PC redirect on any direction or target misprediction. It trains the predictor on every resolved control-flow instruction.

---
 rtl/riscv_branch_pkg.sv | 42 ++++
 rtl/branch_compare.sv | 49 ++++
 rtl/branch_predict_flush_unit.sv | 160 ++++++++++++++++
 tb/tb_branch_predict_flush_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_branch_pkg
// Shared definitions for the branch prediction / flush unit:
//   - RV32I conditional-branch funct3 encodings
//   - 2-bit saturating counter type, encodings and reset value
//   - saturating increment / decrement helpers
// -----------------------------------------------------------------------------
package riscv_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WNT;

    function automatic ctr_t ctr_inc(input ctr_t c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

endpackage

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Combinational RV32I branch condition evaluator.
// Ports:
//   funct3  in  3     branch condition select
//   rs1     in  XLEN  first operand
//   rs2     in  XLEN  second operand
//   cond    out 1     condition true (0 for reserved funct3)
//   legal   out 1     funct3 is one of the six defined branch encodings
// -----------------------------------------------------------------------------
module branch_compare
    import riscv_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            legal
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   eq;
    logic                   lt_s;
    logic                   lt_u;

    assign rs1_s = rs1;
    assign rs2_s = rs2;
    assign eq    = (rs1 == rs2);
    assign lt_s  = (rs1_s < rs2_s);
    assign lt_u  = (rs1 < rs2);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = ~lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = ~lt_u;
            default: legal = 1'b0;  // 010/011: never taken, never trained
        endcase
    end

endmodule

// File: rtl/branch_predict_flush_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_flush_unit
// IF-stage prediction from a direct-mapped BTB + 2-bit counters, EX-stage
// resolution of conditional branches and JAL/JALR, flush/redirect on any
// direction or target misprediction, and predictor training.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN;
// without it br_count/mispred_count are tied to 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_pc                    IF PC; pred_taken / pred_target out
//   ex_valid/ex_branch/ex_jump/ex_funct3/ex_rs1/ex_rs2/ex_pc/ex_target
//   ex_pred_taken/ex_pred_target   EX instruction and its carried prediction
//   branch_taken, flush, redirect_pc   resolution outputs (combinational)
//   br_count, mispred_count  statistics
// -----------------------------------------------------------------------------
module branch_predict_flush_unit
    import riscv_branch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = XLEN - IDX_BITS - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            branch_taken,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q,   tag_d;
    logic [ENTRIES-1:0][XLEN-1:0]      tgt_q,   tgt_d;
    ctr_t                              ctr_q [ENTRIES];
    ctr_t                              ctr_d [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                cond, legal;
    logic                ex_ctl;
    logic                train;
    logic                mispredict;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .cond   (cond),
        .legal  (legal)
    );

    // IF prediction: reads pre-update state, no bypass from the EX write.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && (ctr_q[if_idx] >= CTR_WT);
        pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);
    end

    // EX resolution
    always_comb begin
        ex_ctl       = ex_valid & (ex_branch | ex_jump);
        branch_taken = ex_valid & (ex_jump | (ex_branch & cond));
        mispredict   = ex_ctl &
                       ((branch_taken != ex_pred_taken) ||
                        (branch_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        flush        = mispredict;
        redirect_pc  = '0;
        if (mispredict) begin
            redirect_pc = branch_taken ? ex_target : ex_pc + XLEN'(4);
        end
        train        = ex_ctl & (ex_jump | legal);
    end

    // Training next-state: hit updates the counter, miss replaces the entry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        if (train) begin
            valid_d[ex_idx] = 1'b1;
            tag_d[ex_idx]   = ex_tag;
            if (branch_taken) begin
                tgt_d[ex_idx] = ex_target;
            end
            if (ex_hit) begin
                ctr_d[ex_idx] = branch_taken ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
            end else begin
                ctr_d[ex_idx] = branch_taken ? CTR_WT : CTR_WNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    // Free-running counters, wrap modulo 2^32.
    always_comb begin
        br_count_d      = br_count_q + (train ? 32'd1 : 32'd0);
        mispred_count_d = mispred_count_q + (mispredict ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_flush_unit.sv
module tb_branch_predict_flush_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_target;
    logic        ex_pred_taken;
    logic        branch_taken, flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count, mispred_count;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mis = 0;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    branch_predict_flush_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .branch_taken(branch_taken), .flush(flush), .redirect_pc(redirect_pc),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    // Drive one EX instruction (inputs settle, then #1 for combinational outputs).
    task automatic drive_ex(input bit br, input bit jmp, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input bit pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_branch = br; ex_jump = jmp; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
        #1;
    endtask

    // Clock the current EX instruction into the predictor.
    task automatic commit(input bit tr, input bit fl);
        @(posedge clk); #1;
        if (tr) exp_br++;
        if (fl) exp_mis++;
        idle();
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc; #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_pc = 32'h100;
        idle();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got %0b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL rst_pred_target got %h exp 00000104", pred_target); end
        checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL rst_resolve got %b exp 00", {branch_taken, flush}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect got %h exp 0", redirect_pc); end
        checks++; if ({br_count, mispred_count} !== 64'h0) begin errors++; $display("FAIL rst_stats got %0d/%0d exp 0/0", br_count, mispred_count); end
    endtask

    task automatic test_beq_train();
        drive_ex(1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 0, 32'h104);
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %0b exp 1", branch_taken); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %0b exp 1", flush); end
        checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL beq_redirect got %h exp 00000140", redirect_pc); end
        commit(1, 1);
        look(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_taken got %0b exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h140) begin errors++; $display("FAIL beq_pred_target got %h exp 00000140", pred_target); end
    endtask

    // Entry 0x100 is at 10; two more takens -> 11, then NT -> 10, NT -> 01.
    task automatic test_counter();
        for (int i = 0; i < 2; i++) begin
            drive_ex(1, 0, 3'b000, 32'd7, 32'd7, 32'h100, 32'h140, 1, 32'h140);
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ctr_taken_flush%0d got %0b exp 0", i, flush); end
            commit(1, 0);
        end
        drive_ex(1, 0, 3'b000, 32'd7, 32'd8, 32'h100, 32'h140, 1, 32'h140);
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL ctr_nt1_redirect got %h exp 00000104", redirect_pc); end
        commit(1, 1);
        look(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_after_nt1 got %0b exp 1", pred_taken); end
        drive_ex(1, 0, 3'b000, 32'd7, 32'd8, 32'h100, 32'h140, 1, 32'h140);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ctr_nt2_flush got %0b exp 1", flush); end
        commit(1, 1);
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_after_nt2 got %0b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL ctr_after_nt2_tgt got %h exp 00000104", pred_target); end
    endtask

    task automatic test_compare();
        drive_ex(1, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h1C0, 1, 32'h1C0);
        checks++; if ({branch_taken, flush} !== 2'b10) begin errors++; $display("FAIL blt_signed got %b exp 10", {branch_taken, flush}); end
        commit(1, 0);
        drive_ex(1, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h1C0, 1, 32'h1C0);
        checks++; if ({branch_taken, flush} !== 2'b01) begin errors++; $display("FAIL bltu got %b exp 01", {branch_taken, flush}); end
        checks++; if (redirect_pc !== 32'h184) begin errors++; $display("FAIL bltu_redirect got %h exp 00000184", redirect_pc); end
        commit(1, 1);
        look(32'h180);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bltu_trained got %0b exp 0", pred_taken); end
        // Combinational-only checks, dropped before the next edge.
        drive_ex(1, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h1C0, 0, 32'h184);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bge_signed got %0b exp 0", branch_taken); end
        drive_ex(1, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h1C0, 0, 32'h184);
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bgeu got %0b exp 1", branch_taken); end
        drive_ex(1, 0, 3'b001, 32'd3, 32'd3, 32'h180, 32'h1C0, 0, 32'h184);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne_equal got %0b exp 0", branch_taken); end
        ex_valid = 1'b0; ex_jump = 1'b1; #1;
        checks++; if ({branch_taken, flush, redirect_pc} !== 34'h0) begin errors++; $display("FAIL nonvalid_gate got %b/%h exp 00/0", {branch_taken, flush}, redirect_pc); end
        idle();
    endtask

    // 0x200 shares index 0 with 0x100: training it evicts the 0x100 entry.
    task automatic test_jalr();
        drive_ex(0, 1, 3'b000, 32'd0, 32'd0, 32'h200, 32'h380, 1, 32'h300);
        checks++; if ({branch_taken, flush} !== 2'b11) begin errors++; $display("FAIL jalr_flush got %b exp 11", {branch_taken, flush}); end
        checks++; if (redirect_pc !== 32'h380) begin errors++; $display("FAIL jalr_redirect got %h exp 00000380", redirect_pc); end
        commit(1, 1);
        look(32'h200);
        checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h380}) begin errors++; $display("FAIL jalr_btb got %0b/%h exp 1/00000380", pred_taken, pred_target); end
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got %0b exp 0", pred_taken); end
    endtask

    task automatic test_illegal();
        drive_ex(1, 0, 3'b010, 32'd9, 32'd9, 32'h200, 32'h380, 1, 32'h380);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL illegal_taken got %0b exp 0", branch_taken); end
        checks++; if ({flush, redirect_pc} !== {1'b1, 32'h204}) begin errors++; $display("FAIL illegal_redirect got %0b/%h exp 1/00000204", flush, redirect_pc); end
        commit(0, 1);
        look(32'h200);
        checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h380}) begin errors++; $display("FAIL illegal_no_train got %0b/%h exp 1/00000380", pred_taken, pred_target); end
    endtask

    task automatic test_stats(input string tag);
        checks++; if (br_count !== (STATS ? 32'(exp_br) : 32'd0)) begin errors++; $display("FAIL %s_br_count got %0d exp %0d", tag, br_count, STATS ? exp_br : 0); end
        checks++; if (mispred_count !== (STATS ? 32'(exp_mis) : 32'd0)) begin errors++; $display("FAIL %s_mispred got %0d exp %0d", tag, mispred_count, STATS ? exp_mis : 0); end
    endtask

    task automatic test_reset_override();
        drive_ex(0, 1, 3'b000, 32'd0, 32'd0, 32'h208, 32'h400, 0, 32'h20C);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_br = 0; exp_mis = 0;
        idle();
        look(32'h208);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_override got %0b exp 0", pred_taken); end
        look(32'h200);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_clears_btb got %0b exp 0", pred_taken); end
        test_stats("rst_override");
    endtask

    task automatic test_back_to_back();
        drive_ex(0, 1, 3'b000, 32'd0, 32'd0, 32'h210, 32'h500, 0, 32'h214);
        checks++; if ({flush, redirect_pc} !== {1'b1, 32'h500}) begin errors++; $display("FAIL b2b_first got %0b/%h exp 1/00000500", flush, redirect_pc); end
        @(posedge clk); #1; exp_br++; exp_mis++;
        drive_ex(0, 1, 3'b000, 32'd0, 32'd0, 32'h214, 32'h600, 0, 32'h218);
        checks++; if ({flush, redirect_pc} !== {1'b1, 32'h600}) begin errors++; $display("FAIL b2b_second got %0b/%h exp 1/00000600", flush, redirect_pc); end
        commit(1, 1);
        look(32'h210);
        checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h500}) begin errors++; $display("FAIL b2b_pred0 got %0b/%h exp 1/00000500", pred_taken, pred_target); end
        look(32'h214);
        checks++; if ({pred_taken, pred_target} !== {1'b1, 32'h600}) begin errors++; $display("FAIL b2b_pred1 got %0b/%h exp 1/00000600", pred_taken, pred_target); end
        drive_ex(0, 1, 3'b000, 32'd0, 32'd0, 32'h210, 32'h500, 1, 32'h500);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jal_correct got %0b exp 0", flush); end
        commit(1, 0);
        test_stats("final");
    endtask

    initial begin
        ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        test_reset();
        test_beq_train();
        test_counter();
        test_compare();
        test_jalr();
        test_illegal();
        test_stats("mid");
        test_reset_override();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
